// File: rtl/uart_msg_source.sv
// Message source for the Bluetooth UART transmitter: a baud divider that produces
// baud_clk and baud_tick, and a 32x8 synchronous-read ROM holding the 16-byte message.
module uart_msg_source #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned DIV      = CLK_FREQ / BAUD,
  parameter int unsigned HALF     = DIV / 2,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned MSG_LEN  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        data,
  output logic              baud_clk,
  output logic              baud_tick
);

  localparam int unsigned     CntW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);
  localparam logic [CntW-1:0] CntFall = CntW'(HALF - 1);
  localparam int unsigned     MsgAw   = $clog2(MSG_LEN);

  // "HELLO BLUETOOTH\n"
  localparam logic [7:0] MsgRom [MSG_LEN] = '{
    8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h42, 8'h4C,
    8'h55, 8'h45, 8'h54, 8'h4F, 8'h4F, 8'h54, 8'h48, 8'h0A
  };

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            baud_clk_q, baud_clk_d;
  logic            baud_tick_q, baud_tick_d;
  logic [7:0]      data_q, data_d;

  always_comb begin
    cnt_d       = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    baud_tick_d = (cnt_q == CntLast);
    baud_clk_d  = baud_clk_q;
    // Rising-edge test has priority so a degenerate HALF can never suppress the tick phase.
    if (cnt_q == CntLast) begin
      baud_clk_d = 1'b1;
    end else if (cnt_q == CntFall) begin
      baud_clk_d = 1'b0;
    end
  end

  always_comb begin
    data_d = 8'h00;
    if (32'(addr) < MSG_LEN) begin
      data_d = MsgRom[addr[MsgAw-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      baud_clk_q  <= 1'b0;
      baud_tick_q <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      cnt_q       <= cnt_d;
      baud_clk_q  <= baud_clk_d;
      baud_tick_q <= baud_tick_d;
      data_q      <= data_d;
    end
  end

  assign data      = data_q;
  assign baud_clk  = baud_clk_q;
  assign baud_tick = baud_tick_q;

endmodule

// File: tb/tb_uart_msg_source.sv
// Self-checking bench for uart_msg_source: divider timing at DIV=16, 5 and 2, ROM sweep,
// read latency and asynchronous reset behaviour.
module tb_uart_msg_source;

  logic       clk;
  logic       rst_n;
  logic [4:0] addr;
  logic [7:0] data16, data5, data2;
  logic       bclk16, bclk5, bclk2;
  logic       tick16, tick5, tick2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
  } rom_vec_t;

  rom_vec_t   vecs [32];
  logic [7:0] msg  [16];
  logic [7:0] exp_q [$];

  uart_msg_source #(.CLK_FREQ(16), .BAUD(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .addr(addr),
    .data(data16), .baud_clk(bclk16), .baud_tick(tick16)
  );

  uart_msg_source #(.CLK_FREQ(5), .BAUD(1)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .addr(addr),
    .data(data5), .baud_clk(bclk5), .baud_tick(tick5)
  );

  uart_msg_source #(.CLK_FREQ(2), .BAUD(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .addr(addr),
    .data(data2), .baud_clk(bclk2), .baud_tick(tick2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string name, input logic [7:0] act);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({name, " (scoreboard empty)"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(name, {24'd0, act}, {24'd0, e});
    end
  endtask

  initial begin
    msg = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h42, 8'h4C,
            8'h55, 8'h45, 8'h54, 8'h4F, 8'h4F, 8'h54, 8'h48, 8'h0A};
    for (int i = 0; i < 32; i++) begin
      vecs[i].addr = 5'(i);
      vecs[i].data = (i < 16) ? msg[i] : 8'h00;
    end

    // Reset held with clock running.
    rst_n = 1'b0;
    addr  = 5'd3;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("reset data",      {24'd0, data16}, 32'h0);
      check("reset baud_clk",  {31'd0, bclk16}, 32'd0);
      check("reset baud_tick", {31'd0, tick16}, 32'd0);
      check("reset tick5",     {31'd0, tick5},  32'd0);
      check("reset tick2",     {31'd0, tick2},  32'd0);
      step();
    end

    // Divider timing: edge k counts rising clk edges since release.
    rst_n = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      step();
      check("div16 tick", {31'd0, tick16}, {31'd0, (k % 16) == 0});
      check("div16 bclk", {31'd0, bclk16}, {31'd0, (k >= 16) && ((k % 16) < 8)});
      check("div5 tick",  {31'd0, tick5},  {31'd0, (k % 5) == 0});
      check("div5 bclk",  {31'd0, bclk5},  {31'd0, (k >= 5) && ((k % 5) < 2)});
      check("div2 tick",  {31'd0, tick2},  {31'd0, (k % 2) == 0});
      check("div2 bclk",  {31'd0, bclk2},  {31'd0, (k >= 2) && ((k % 2) == 0)});
    end

    // ROM sweep through the scoreboard.
    for (int i = 0; i < 32; i++) begin
      addr = vecs[i].addr;
      exp_q.push_back(vecs[i].data);
      step();
      pop_check($sformatf("rom[%0d]", i), data16);
    end

    // Latency: addr changes between edges are invisible until the next edge.
    addr = 5'd0;
    step();
    check("lat addr0", {24'd0, data16}, 32'h48);
    addr = 5'd14;
    #2;
    check("lat hold before edge 14", {24'd0, data16}, 32'h48);
    exp_q.push_back(8'h48);
    step();
    pop_check("lat entry14", data16);
    addr = 5'd15;
    #2;
    check("lat hold before edge 15", {24'd0, data16}, 32'h48);
    exp_q.push_back(8'h0A);
    step();
    pop_check("lat entry15", data16);
    addr = 5'd16;
    #2;
    check("lat hold 0A", {24'd0, data16}, 32'h0A);
    exp_q.push_back(8'h00);
    step();
    pop_check("lat entry16", data16);

    // Async reset mid-run at cnt=10 on the DIV=16 divider.
    addr  = 5'd0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) step();
    check("pre-rst data",  {24'd0, data16}, 32'h48);
    check("pre-rst bclk16", {31'd0, bclk16}, 32'd0);
    check("pre-rst tick5", {31'd0, tick5},  32'd1);
    check("pre-rst bclk5", {31'd0, bclk5},  32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async data",  {24'd0, data16}, 32'h0);
    check("async bclk16", {31'd0, bclk16}, 32'd0);
    check("async tick16", {31'd0, tick16}, 32'd0);
    check("async tick5", {31'd0, tick5},  32'd0);
    check("async bclk5", {31'd0, bclk5},  32'd0);
    check("async data5", {24'd0, data5},  32'h0);
    step();
    check("rst hold data", {24'd0, data16}, 32'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      check("post-rst tick16", {31'd0, tick16}, {31'd0, k == 16});
      check("post-rst bclk16", {31'd0, bclk16}, {31'd0, k >= 16});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_msg_source.md
Name: uart_msg_source

Overview:
- Message-source front end for the Bluetooth UART transmitter.
- Contains a baud-rate divider that produces a baud clock and a one-cycle baud tick from the system clock.
- Contains a 32x8 synchronous-read ROM holding the fixed 16-byte message that the byte serializer sends.
- The serializer drives `addr` and samples `data` at baud rate. It sends only addresses 0..15.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 9600: serial bit rate in bit/s.
- DIV, CLK_FREQ/BAUD (integer division): clocks per bit period. Must be >= 2.
- HALF, DIV/2 (integer division): clocks from the baud_clk rising edge to its falling edge.
- ADDR_W, 5: ROM address width.
- MSG_LEN, 16: number of valid message bytes.

Ports:
- clk, input, 1: system clock; all logic acts on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- addr, input, ADDR_W: ROM read address.
- data, output, 8: ROM read data, registered.
- baud_clk, output, 1: baud square wave with period DIV clocks.
- baud_tick, output, 1: one-clock pulse at each baud_clk rising edge.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - cnt=0, baud_clk=0, baud_tick=0, data=8'h00.
  - On release, counting starts on the first clk rising edge.
- Baud divider:
  - cnt is a register with width ceil(log2(DIV)).
  - Each edge: cnt <= (cnt==DIV-1) ? 0 : cnt+1.
  - baud_tick <= (cnt==DIV-1). It is high exactly one clock per DIV clocks.
  - baud_clk <= 1 when cnt==DIV-1.
  - baud_clk <= 0 when cnt==HALF-1 (only if HALF-1 != DIV-1).
  - Otherwise baud_clk holds its value.
  - First rising edge of baud_clk, with baud_tick=1 in the same cycle, occurs DIV clocks after reset release. Subsequent rising edges occur every DIV clocks.
  - baud_clk is high for HALF clocks and low for DIV-HALF clocks. For odd DIV the low phase is one clock longer.
  - DIV=2 gives baud_clk = a clk/2 square wave and baud_tick = every other cycle.
- ROM:
  - 32 entries, read-only, content fixed at elaboration.
  - data <= rom[addr] on every clk rising edge. No enable.
  - Read latency is 1 clock. A changed addr is visible on data after the next edge.
  - Entries 0..15 hold ASCII "HELLO BLUETOOTH\n": 48 45 4C 4C 4F 20 42 4C 55 45 54 4F 4F 54 48 0A (hex).
  - Entries 16..31 read 8'h00.
  - Address wrap: addr is exactly ADDR_W bits, so no out-of-range case exists.
- Reset mid-operation:
  - All three outputs drop to their reset values immediately, without waiting for a clock edge.
  - Divider phase restarts from cnt=0.
- The divider and ROM are independent; neither stalls the other.

Test Plan:
- Reset check: rst_n=0 with addr=3 and clk running -> data=00, baud_clk=0, baud_tick=0 throughout reset.
- Divider timing (CLK_FREQ=16, BAUD=1, DIV=16, HALF=8):
  - release reset -> baud_tick pulses at clocks 16, 32, 48 after release, each one clock wide.
  - baud_clk rises at those same clocks and stays high for 8 clocks.
- Odd and minimum DIV:
  - DIV=5 (CLK_FREQ=5, BAUD=1) -> baud_clk high 2 clocks, low 3 clocks, period 5.
  - DIV=2 -> baud_clk toggles every clock; baud_tick=1 on every other clock.
- ROM sweep: addr=0..31 applied one per clock -> data one cycle later reads 48,45,4C,4C,4F,20,42,4C,55,45,54,4F,4F,54,48,0A, then sixteen 00 values.
- Latency: addr changes 0->14 between edges -> data=48 until the next edge, then 48 (entry 14) ... then switch addr to 15 -> 0A after one edge.
- Async reset mid-run: assert rst_n=0 at cnt=10 (DIV=16) while baud_clk=0 -> outputs go to 0 without a clock edge. After release, the next baud_tick comes exactly 16 clocks later.
